wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 3PA pipeline. Holds the MEM/WB pipeline register and selects the writeback value (ALU result, load data, PC+4 or immediate).
- Waits for late load data through a valid handshake with the data-memory interface, and raises a stall request while it waits.
- Drives the register file write port and feeds the one-cycle-delayed forwarding stage (`rdst`, `reg_write_rf`, `mux` triplet) directly.

Parameters:
- WIDTH, 32, datapath width in bits.
- RADDR, 5, register-address width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  global pipeline stall from the hazard unit; freezes the stage register.
- i_flush  in  1  loads a bubble instead of the MEM inputs; ignored when stall=1.
- i_wb_valid  in  1  MEM stage presents a valid instruction.
- i_wb_rdst  in  RADDR  destination register.
- i_wb_reg_write_rf  in  1  instruction writes the register file.
- i_wb_sel  in  2  writeback source: 0=ALU, 1=MEM, 2=PC+4, 3=IMM.
- i_wb_alu  in  WIDTH  ALU result; bits [1:0] are the load byte offset.
- i_wb_pc4  in  WIDTH  PC+4.
- i_wb_imm  in  WIDTH  immediate, e.g. LUI.
- i_wb_lsize  in  2  load size: 0=byte, 1=half, 2=word, 3=word.
- i_wb_lsigned  in  1  sign-extend sub-word loads.
- i_mem_rvalid  in  1  load data valid this cycle.
- i_mem_rdata  in  WIDTH  load data word.
- o_wb_rdst  out  RADDR  destination register to the register file.
- o_wb_reg_write_rf  out  1  register file write enable.
- o_wb_mux  out  WIDTH  writeback value.
- o_wb_stall_req  out  1  stall request to the hazard unit: load data outstanding.

Behaviour:
- Stage register, updated at posedge clk:
  - rst: all fields 0; state S_IDLE; data-captured flag 0.
  - else if stall=1: hold all fields and state. The one exception is S_WAIT with i_mem_rvalid=1: data is still captured.
  - else if i_flush=1 or i_wb_valid=0: bubble, state S_IDLE.
  - else: capture all i_wb_* inputs. Next state is S_WAIT when i_wb_sel=1, otherwise S_ACTIVE.
- States:
  - S_IDLE: no instruction held. o_wb_reg_write_rf=0, o_wb_stall_req=0.
  - S_ACTIVE: result complete. Stays S_ACTIVE only if a new instruction is captured; otherwise follows the capture rules above.
  - S_WAIT: load held, data not yet captured.
    - i_mem_rvalid=1: latch i_mem_rdata, go to S_ACTIVE regardless of stall.
    - i_mem_rvalid=0: stay in S_WAIT.
    - The stage register is frozen in S_WAIT; new MEM inputs are not captured.
- o_wb_stall_req = (state==S_WAIT) & ~i_mem_rvalid, combinational.
  - Data that arrives in S_WAIT is forwarded combinationally in that same cycle: load data comes from i_mem_rdata, o_wb_reg_write_rf may assert, and stall_req deasserts.
  - Load-to-write latency is 0 cycles after rvalid.
- Outputs are combinational from the stage register (plus i_mem_rdata in S_WAIT):
  - o_wb_rdst = held rdst; forced to 0 in S_IDLE.
  - o_wb_reg_write_rf = held reg_write_rf & (state==S_ACTIVE | (state==S_WAIT & i_mem_rvalid)) & (rdst!=0). r0 is never written.
  - o_wb_mux by sel: 0 → alu, 1 → aligned load data, 2 → pc4, 3 → imm. Output is 0 in S_IDLE.
- i_mem_rvalid outside S_WAIT is ignored.
- rst while in S_WAIT aborts the load; a later rvalid is ignored.
- No arithmetic beyond the load extraction. All values are WIDTH bits; no carries.

Optional Feature:
- Macro: WB_LOAD_ALIGN_EN.
- Defined:
  - Byte load: extract the byte at offset alu[1:0] (little-endian).
  - Half load: extract the halfword at alu[1]; alu[0] is ignored.
  - Sub-word results are zero-extended, or sign-extended when lsigned=1.
- Undefined: load data passes through as a full word; lsize, lsigned and the offset are ignored.

Test Plan:
- ALU op: valid, sel=0, rdst=5, we=1, alu=0x12345678 → next cycle state S_ACTIVE, rdst=5, we=1, mux=0x12345678, stall_req=0.
- Write to r0: rdst=0, we=1, sel=2, pc4=0x104 → mux=0x104, o_wb_reg_write_rf=0.
- Late load: sel=1, rdst=7, rvalid low for 3 cycles.
  - stall_req=1 and we=0 for those 3 cycles; new inputs are not captured.
  - Cycle rvalid=1, rdata=0xCAFEBABE: mux=0xCAFEBABE, we=1, stall_req=0. Next cycle the new MEM instruction is captured.
- WB_LOAD_ALIGN_EN, rdata=0x80FF7F01:
  - lsize=0, lsigned=1, alu[1:0]=2 → 0xFFFFFFFF.
  - lsize=0, lsigned=0, alu[1:0]=3 → 0x00000080.
  - lsize=1, lsigned=1, alu[1]=0 → 0x00007F01.
- Stall/flush precedence:
  - stall=1 with an ALU op held: outputs unchanged across 2 cycles.
  - stall=0, flush=1 → S_IDLE, we=0, mux=0, rdst=0.
- rst during S_WAIT, then rvalid=1 → outputs all 0, state S_IDLE, no write.

Source files
------------

// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage, data memory and the writeback stage.
// Carries the MEM/WB inputs, the load-data handshake and the regfile write port.
interface wb_stage_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic             i_wb_valid;
  logic [RADDR-1:0] i_wb_rdst;
  logic             i_wb_reg_write_rf;
  logic [1:0]       i_wb_sel;
  logic [WIDTH-1:0] i_wb_alu;
  logic [WIDTH-1:0] i_wb_pc4;
  logic [WIDTH-1:0] i_wb_imm;
  logic [1:0]       i_wb_lsize;
  logic             i_wb_lsigned;
  logic             i_mem_rvalid;
  logic [WIDTH-1:0] i_mem_rdata;
  logic [RADDR-1:0] o_wb_rdst;
  logic             o_wb_reg_write_rf;
  logic [WIDTH-1:0] o_wb_mux;
  logic             o_wb_stall_req;

  modport master (
    output i_wb_valid, i_wb_rdst, i_wb_reg_write_rf,
    output i_wb_sel, i_wb_alu, i_wb_pc4, i_wb_imm,
    output i_wb_lsize, i_wb_lsigned,
    output i_mem_rvalid, i_mem_rdata,
    input  o_wb_rdst, o_wb_reg_write_rf,
    input  o_wb_mux, o_wb_stall_req
  );

  modport slave (
    input  i_wb_valid, i_wb_rdst, i_wb_reg_write_rf,
    input  i_wb_sel, i_wb_alu, i_wb_pc4, i_wb_imm,
    input  i_wb_lsize, i_wb_lsigned,
    input  i_mem_rvalid, i_mem_rdata,
    output o_wb_rdst, o_wb_reg_write_rf,
    output o_wb_mux, o_wb_stall_req
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, late-load wait, writeback select.
// WB_LOAD_ALIGN_EN enables byte/half load extraction with sign extension.
module wb_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic i_flush,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [RADDR-1:0] rdst;
    logic             we;
    logic [1:0]       sel;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       lsize;
    logic             lsigned;
  } mem_wb_t;

  state_t  state;
  mem_wb_t r;

  logic [WIDTH-1:0] ld_word;
  logic [WIDTH-1:0] ld_val;
  logic             fire;

`ifdef WB_LOAD_ALIGN_EN
  logic [WIDTH-1:0] sh;
  logic [7:0]       b;
  logic [15:0]      h;

  always_comb begin
    sh = ld_word >> {r.alu[1:0], 3'b000};
    b  = sh[7:0];
    h  = r.alu[1] ? ld_word[31:16] : ld_word[15:0];
    unique case (1'b1)
      (r.lsize == 2'd0):
        ld_val = {{(WIDTH-8){r.lsigned & b[7]}}, b};
      (r.lsize == 2'd1):
        ld_val = {{(WIDTH-16){r.lsigned & h[15]}}, h};
      default:
        ld_val = ld_word;
    endcase
  end
`else
  logic unused_align;

  assign unused_align = ^{r.lsize, r.lsigned};
  assign ld_val       = ld_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      r     <= '0;
    end else if (state == S_WAIT) begin
      // Frozen until data arrives; capture happens even under stall.
      if (bus.i_mem_rvalid) begin
        r.rdata <= bus.i_mem_rdata;
        state   <= S_ACTIVE;
      end
    end else if (!stall) begin
      if (i_flush || !bus.i_wb_valid) begin
        r     <= '0;
        state <= S_IDLE;
      end else begin
        r.rdst    <= bus.i_wb_rdst;
        r.we      <= bus.i_wb_reg_write_rf;
        r.sel     <= bus.i_wb_sel;
        r.alu     <= bus.i_wb_alu;
        r.pc4     <= bus.i_wb_pc4;
        r.imm     <= bus.i_wb_imm;
        r.rdata   <= '0;
        r.lsize   <= bus.i_wb_lsize;
        r.lsigned <= bus.i_wb_lsigned;
        state     <= (bus.i_wb_sel == 2'd1) ? S_WAIT
                                            : S_ACTIVE;
      end
    end
  end

  assign ld_word = (state == S_WAIT) ? bus.i_mem_rdata
                                     : r.rdata;

  assign fire = (state == S_ACTIVE) ||
                (state == S_WAIT && bus.i_mem_rvalid);

  always_comb begin
    bus.o_wb_mux = '0;
    unique case (1'b1)
      (r.sel == 2'd0): bus.o_wb_mux = r.alu;
      (r.sel == 2'd1): bus.o_wb_mux = ld_val;
      (r.sel == 2'd2): bus.o_wb_mux = r.pc4;
      default:         bus.o_wb_mux = r.imm;
    endcase
    if (state == S_IDLE) bus.o_wb_mux = '0;
  end

  assign bus.o_wb_rdst = (state == S_IDLE) ? '0 : r.rdst;

  assign bus.o_wb_reg_write_rf =
    r.we & fire & (r.rdst != '0);

  assign bus.o_wb_stall_req =
    (state == S_WAIT) & ~bus.i_mem_rvalid;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic i_flush;

  wb_stage_if #(.WIDTH(32), .RADDR(5)) bus ();

  wb_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .i_flush (i_flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rdst;
    logic        we;
    logic [31:0] mux;
    logic        sreq;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      if (bus.o_wb_rdst === e.rdst &&
          bus.o_wb_reg_write_rf === e.we &&
          bus.o_wb_mux === e.mux &&
          bus.o_wb_stall_req === e.sreq)
        n_pass++;
      else
        $display("FAIL %s: got rdst=%0d we=%b mux=%h sreq=%b, want rdst=%0d we=%b mux=%h sreq=%b",
                 e.name, bus.o_wb_rdst, bus.o_wb_reg_write_rf,
                 bus.o_wb_mux, bus.o_wb_stall_req,
                 e.rdst, e.we, e.mux, e.sreq);
    end
  end

  task automatic idle_in();
    stall                 = 1'b0;
    i_flush               = 1'b0;
    bus.i_wb_valid        = 1'b0;
    bus.i_wb_rdst         = '0;
    bus.i_wb_reg_write_rf = 1'b0;
    bus.i_wb_sel          = 2'd0;
    bus.i_wb_alu          = '0;
    bus.i_wb_pc4          = '0;
    bus.i_wb_imm          = '0;
    bus.i_wb_lsize        = 2'd2;
    bus.i_wb_lsigned      = 1'b0;
    bus.i_mem_rvalid      = 1'b0;
    bus.i_mem_rdata       = '0;
  endtask

  task automatic op(input logic [1:0] sel,
                    input logic [4:0] rd,
                    input logic [31:0] alu);
    bus.i_wb_valid        = 1'b1;
    bus.i_wb_sel          = sel;
    bus.i_wb_rdst         = rd;
    bus.i_wb_reg_write_rf = 1'b1;
    bus.i_wb_alu          = alu;
  endtask

  task automatic chk(input string n,
                     input logic [4:0] rd,
                     input logic we,
                     input logic [31:0] mux,
                     input logic sreq);
    exp_t e;
    e.name = n;
    e.rdst = rd;
    e.we   = we;
    e.mux  = mux;
    e.sreq = sreq;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input string n,
                           input logic [31:0] alu,
                           input logic [1:0] sz,
                           input logic sg,
                           input logic [31:0] aligned);
    logic [31:0] x;
`ifdef WB_LOAD_ALIGN_EN
    x = aligned;
`else
    x = 32'h80FF7F01;
`endif
    idle_in();
    op(2'd1, 5'd3, alu);
    bus.i_wb_lsize   = sz;
    bus.i_wb_lsigned = sg;
    chk({n, "_iss"}, 5'd0, 1'b0, 32'h0, 1'b0);
    idle_in();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h80FF7F01;
    chk(n, 5'd3, 1'b1, x, 1'b0);
    idle_in();
    chk({n, "_hold"}, 5'd3, 1'b1, x, 1'b0);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset", 5'd0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;

    op(2'd0, 5'd5, 32'h12345678);
    chk("alu_iss", 5'd0, 1'b0, 32'h0, 1'b0);
    idle_in();
    chk("alu", 5'd5, 1'b1, 32'h12345678, 1'b0);

    op(2'd2, 5'd0, 32'h0);
    bus.i_wb_pc4 = 32'h104;
    chk("r0_iss", 5'd0, 1'b0, 32'h0, 1'b0);
    idle_in();
    chk("r0", 5'd0, 1'b0, 32'h104, 1'b0);

    op(2'd1, 5'd7, 32'h0);
    chk("ld_iss", 5'd0, 1'b0, 32'h0, 1'b0);
    op(2'd0, 5'd9, 32'hAAAA5555);
    for (int i = 0; i < 3; i++)
      chk("ld_wait", 5'd7, 1'b0, 32'h0, 1'b1);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hCAFEBABE;
    chk("ld_data", 5'd7, 1'b1, 32'hCAFEBABE, 1'b0);
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0;
    chk("ld_hold", 5'd7, 1'b1, 32'hCAFEBABE, 1'b0);
    idle_in();
    chk("ld_next", 5'd9, 1'b1, 32'hAAAA5555, 1'b0);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h11111111;
    chk("rv_idle", 5'd0, 1'b0, 32'h0, 1'b0);

    load_case("lb_s2",  32'h2, 2'd0, 1'b1, 32'hFFFFFFFF);
    load_case("lb_u3",  32'h3, 2'd0, 1'b0, 32'h00000080);
    load_case("lb_s1",  32'h1, 2'd0, 1'b1, 32'h0000007F);
    load_case("lh_s0",  32'h0, 2'd1, 1'b1, 32'h00007F01);
    load_case("lh_s3",  32'h3, 2'd1, 1'b1, 32'hFFFF80FF);
    load_case("lw",     32'h1, 2'd2, 1'b1, 32'h80FF7F01);

    idle_in();
    op(2'd0, 5'd4, 32'h55);
    chk("st_iss", 5'd0, 1'b0, 32'h0, 1'b0);
    op(2'd3, 5'd6, 32'h66);
    bus.i_wb_imm = 32'h77;
    stall = 1'b1;
    chk("stall1", 5'd4, 1'b1, 32'h55, 1'b0);
    i_flush = 1'b1;
    chk("stall2", 5'd4, 1'b1, 32'h55, 1'b0);
    stall = 1'b0;
    chk("flush_pre", 5'd4, 1'b1, 32'h55, 1'b0);
    idle_in();
    chk("flush", 5'd0, 1'b0, 32'h0, 1'b0);

    op(2'd1, 5'd8, 32'h0);
    chk("sw_iss", 5'd0, 1'b0, 32'h0, 1'b0);
    idle_in();
    stall            = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h1234;
    chk("sw_data", 5'd8, 1'b1, 32'h1234, 1'b0);
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0;
    chk("sw_hold", 5'd8, 1'b1, 32'h1234, 1'b0);
    stall = 1'b0;
    chk("sw_rel", 5'd8, 1'b1, 32'h1234, 1'b0);
    chk("sw_idle", 5'd0, 1'b0, 32'h0, 1'b0);

    op(2'd1, 5'd10, 32'h0);
    chk("rw_iss", 5'd0, 1'b0, 32'h0, 1'b0);
    idle_in();
    chk("rw_wait", 5'd10, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    chk("rw_rst", 5'd10, 1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hDEADBEEF;
    chk("rw_abort", 5'd0, 1'b0, 32'h0, 1'b0);
    idle_in();
    chk("rw_after", 5'd0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
